// File: rtl/pw_md4_block_builder.sv
// Builds the single 512-bit MD4 message block for an NT hash: UTF-16LE expansion of a
// captured password (up to 20 characters), the 0x80 pad byte and the 64-bit bit-length.
module pw_md4_block_builder (
  input  logic         clk,
  input  logic         rst,
  input  logic [159:0] in_password,
  input  logic [4:0]   in_length,
  input  logic         trigger,
  output logic [511:0] out_block,
  output logic         busy,
  output logic         out_error,
  output logic         completed
);

  localparam logic [4:0] MAX_LEN = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_PAD,
    S_LEN,
    S_DONE1,
    S_DONE2,
    S_DONE3
  } state_e;

  state_e         state_q;
  logic [511:0]   block_q;
  logic           busy_q;
  logic           err_q;
  logic           comp_q;
  logic [4:0]     idx_q;
  logic           trig_q;
  logic [159:0]   pw_q;
  logic [4:0]     len_q;

  // Combinational helpers feeding the state machine.
  logic           trig_rise_d;
  logic           last_char_d;
  logic [7:0]     char_d;
  logic [8:0]     emit_pos_d;
  logic [8:0]     pad_pos_d;
  logic [15:0]    bit_len_d;

  always_comb begin
    trig_rise_d = trigger & ~trig_q;
    last_char_d = (idx_q == (len_q - 5'd1));
    char_d      = pw_q[{idx_q, 3'b000} +: 8];
    // Each character occupies two bytes (UTF-16LE), so byte 2*i sits at bit 16*i.
    emit_pos_d  = {idx_q, 4'b0000};
    pad_pos_d   = {len_q, 4'b0000};
    bit_len_d   = {7'd0, len_q, 4'b0000};
  end

  // NOTE: the capture registers carry no reset; they are always loaded at capture
  // before anything reads them, so resetting 165 extra flops would buy nothing.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && trig_rise_d && !rst) begin
      pw_q  <= in_password;
      len_q <= in_length;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      block_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      comp_q  <= 1'b0;
      idx_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      trig_q <= trigger;
      unique case (state_q)
        S_IDLE: begin
          if (trig_rise_d) begin
            block_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            if (in_length > MAX_LEN) begin
              err_q   <= 1'b1;
              state_q <= S_DONE1;
            end else if (in_length == 5'd0) begin
              state_q <= S_PAD;
            end else begin
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          // High byte of each UTF-16 code unit stays 0x00 from the clear at capture.
          block_q[emit_pos_d +: 8] <= char_d;
          idx_q                    <= idx_q + 5'd1;
          if (last_char_d) state_q <= S_PAD;
        end
        S_PAD: begin
          block_q[pad_pos_d +: 8] <= 8'h80;
          state_q                 <= S_LEN;
        end
        S_LEN: begin
          // Bytes 56..57 hold the message length in bits; bytes 58..63 remain zero.
          block_q[448 +: 16] <= bit_len_d;
          state_q            <= S_DONE1;
        end
        S_DONE1: begin
          comp_q  <= 1'b1;
          state_q <= S_DONE2;
        end
        S_DONE2: begin
          comp_q  <= 1'b1;
          state_q <= S_DONE3;
        end
        S_DONE3: begin
          comp_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_block = block_q;
  assign busy      = busy_q;
  assign out_error = err_q;
  assign completed = comp_q;

endmodule

// File: tb/tb_pw_md4_block_builder.sv
// Scoreboard bench for pw_md4_block_builder: directed requests push hand-computed
// blocks; a monitor compares them on each completed pulse.
module tb_pw_md4_block_builder;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] in_password;
  logic [4:0]   in_length;
  logic         trigger;
  logic [511:0] out_block;
  logic         busy;
  logic         out_error;
  logic         completed;

  pw_md4_block_builder dut (
    .clk        (clk),
    .rst        (rst),
    .in_password(in_password),
    .in_length  (in_length),
    .trigger    (trigger),
    .out_block  (out_block),
    .busy       (busy),
    .out_error  (out_error),
    .completed  (completed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] blk;
    logic         err;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [511:0] exp_blk;
  int           cycle = 0;
  int           checks = 0;
  int           errors = 0;
  logic         comp_prev = 1'b0;
  int           run = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_byte(input int k, input logic [7:0] v);
    exp_blk[8*k +: 8] = v;
  endtask

  // Monitor: pops one expectation per rising completed, then checks pulse width.
  always @(negedge clk) begin
    if (!rst) begin
      if (completed && !comp_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_completed", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("block", out_block, mon_e.blk);
          check("out_error", out_error, mon_e.err);
          check("latency_cycle", cycle, mon_e.due);
          check("busy_during_completed", busy, 1'b1);
        end
      end
      if (completed) begin
        run++;
      end else if (comp_prev) begin
        check("completed_width", run, 2);
        check("busy_after_completed", busy, 1'b0);
        run = 0;
      end
    end
    comp_prev = completed;
  end

  // Drives one trigger pulse; E0 is the next posedge. lat is edges from E0 to completed.
  task automatic issue(input logic [159:0] pw, input logic [4:0] len,
                       input logic err, input int lat, input logic push);
    exp_t e;
    @(negedge clk);
    in_password = pw;
    in_length   = len;
    trigger     = 1'b1;
    if (push) begin
      e.blk = exp_blk;
      e.err = err;
      e.due = cycle + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, n < 100, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    trigger     = 1'b0;
    in_password = '0;
    in_length   = '0;
    repeat (2) @(negedge clk);
    check("reset_block", out_block, '0);
    check("reset_flags", {busy, out_error, completed}, 3'b000);
    rst = 1'b0;

    // L=0: only the pad byte; password content is ignored.
    exp_blk = '0;
    put_byte(0, 8'h80);
    issue(160'hFF, 5'd0, 1'b0, 3, 1'b1);
    wait_idle("l0");

    // L=1 'a'
    exp_blk = '0;
    put_byte(0, 8'h61); put_byte(2, 8'h80); put_byte(56, 8'h10);
    issue(160'h61, 5'd1, 1'b0, 4, 1'b1);
    wait_idle("l1");

    // L=20 of '~': 320 bits = 0x0140
    exp_blk = '0;
    for (int i = 0; i < 20; i++) put_byte(2*i, 8'h7E);
    put_byte(40, 8'h80); put_byte(56, 8'h40); put_byte(57, 8'h01);
    issue({20{8'h7E}}, 5'd20, 1'b0, 23, 1'b1);
    wait_idle("l20");

    // L=25 error: zero block, completed after E1
    exp_blk = '0;
    issue(160'hDEADBEEF, 5'd25, 1'b1, 1, 1'b1);
    wait_idle("l25");

    // L=2 "AB" clears the error
    exp_blk = '0;
    put_byte(0, 8'h41); put_byte(2, 8'h42); put_byte(4, 8'h80); put_byte(56, 8'h20);
    issue(160'h4241, 5'd2, 1'b0, 5, 1'b1);
    wait_idle("l2");

    // Trigger held 40 cycles, password and length changed mid-EMIT: one "HELLO" block.
    exp_blk = '0;
    put_byte(0, 8'h48); put_byte(2, 8'h45); put_byte(4, 8'h4C);
    put_byte(6, 8'h4C); put_byte(8, 8'h4F); put_byte(10, 8'h80); put_byte(56, 8'h50);
    @(negedge clk);
    in_password = 160'h4F4C4C4548;
    in_length   = 5'd5;
    trigger     = 1'b1;
    mon_e.blk = exp_blk; mon_e.err = 1'b0; mon_e.due = cycle + 1 + 8;
    sb.push_back(mon_e);
    repeat (2) @(negedge clk);
    in_password = '1;
    in_length   = 5'd20;
    repeat (38) @(negedge clk);
    trigger = 1'b0;
    wait_idle("held");

    // "test" with extra pulses while busy: still exactly one block.
    exp_blk = '0;
    put_byte(0, 8'h74); put_byte(2, 8'h65); put_byte(4, 8'h73);
    put_byte(6, 8'h74); put_byte(8, 8'h80); put_byte(56, 8'h40);
    issue(160'h74736574, 5'd4, 1'b0, 7, 1'b1);
    repeat (2) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_idle("pulses");
    repeat (4) @(negedge clk);

    // Reset in the middle of an L=10 EMIT aborts it.
    issue(160'h3938373635343332313A, 5'd10, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_emit_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_block", out_block, '0);
    check("abort_flags", {busy, out_error, completed}, 3'b000);
    rst = 1'b0;

    // Fresh "abc"
    exp_blk = '0;
    put_byte(0, 8'h61); put_byte(2, 8'h62); put_byte(4, 8'h63);
    put_byte(6, 8'h80); put_byte(56, 8'h30);
    issue(160'h636261, 5'd3, 1'b0, 6, 1'b1);
    wait_idle("abc");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pw_md4_block_builder.md
Name: pw_md4_block_builder

Overview:
- Consumer of the password incrementer's output bus: takes a 160-bit password and 5-bit length on a trigger pulse and builds the single 512-bit MD4 message block for the NT hash.
- NT hash input is UTF-16LE of the password, padded per MD4.
- Processes one character per cycle and signals completion with the same 2-cycle `completed` pulse convention the incrementer uses.
- Sits between the password generator and the MD4 core.

Parameters:
None. Maximum length is fixed at 20 characters, set by the 160-bit bus.

Ports:
clk  input  1  system clock; one clock, all logic on rising edge
rst  input  1  reset; reset is synchronous and active-high
in_password  input  160  character i = in_password[8i+7:8i]; character 0 is the first character
in_length  input  5  number of valid characters, 0..31 encodable
trigger  input  1  start request; acts on its rising edge
out_block  output  512  MD4 block; byte k = out_block[8k+7:8k]; word j = out_block[32j+31:32j] (little-endian)
busy  output  1  high from capture until return to IDLE
out_error  output  1  in_length > 20 on last request
completed  output  1  completion pulse, high for exactly 2 cycles

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; out_block=0, busy=0, out_error=0, completed=0.
  - Char index=0, internal trigger-history flop=0.
  - Overrides any state, including mid-EMIT or mid-completion.
- Trigger detection:
  - Internal flop samples trigger every cycle; a rising edge is trigger=1 with flop=0.
  - If trigger is already high when rst deasserts, the first non-reset cycle counts as a rising edge.
  - Rising edges outside IDLE are ignored; no queueing.
  - A trigger held high never retriggers.
- States:
  - IDLE: on rising edge (edge E0):
    - Latch password and length.
    - out_block<=0, out_error<=0, busy<=1, index<=0.
    - If length>20: out_error<=1, go DONE1.
    - Else if length==0: go PAD.
    - Else: go EMIT.
  - EMIT: write byte 2*index <= char[index]; byte 2*index+1 stays 0x00.
    - index<=index+1.
    - After index==length-1, go PAD. One character per cycle (edges E1..EL).
  - PAD: byte 2L <= 0x80 (edge EL+1); go LEN.
  - LEN: bytes 56..57 <= 16*L (bit count of UTF-16 message, 0..320, little-endian); bytes 58..63 stay 0. Edge EL+2; go DONE1.
  - DONE1: completed<=1; go DONE2.
  - DONE2: completed held 1; go DONE3.
  - DONE3: completed<=0, busy<=0; go IDLE.
- Latency:
  - Valid length: completed rises after edge EL+3, stays high 2 cycles, busy falls with it.
  - Error: completed rises after edge E1.
- Data validity:
  - out_block is final and stable from LEN until the next capture.
  - On error, out_block is all zeros.
- Inputs are used only at capture; later changes to in_password/in_length do not affect the block in progress.
- Character values are not range-checked; any 8-bit value is copied verbatim.
- Bytes 2L+1..55 are always 0x00.

Test Plan:
- L=0, trigger pulse -> byte0=0x80, all other bytes 0; completed high 2 cycles starting after edge E3; out_error=0.
- L=1, char0=0x61 -> bytes 0..2 = 61 00 80, byte56=0x10, rest 0; completed after edge E4.
- L=20, all chars 0x7E -> bytes 0..39 alternate 7E/00, byte40=0x80, byte56=0x40, byte57=0x01; completed after edge E23 lasting 2 cycles; busy low afterwards.
- L=25 -> out_error=1, out_block all zero, completed after edge E1; next valid request with L=2 clears out_error.
- Trigger held high for 40 cycles, plus extra pulses while busy -> exactly one block built and one 2-cycle completed pulse. Changing in_password mid-EMIT does not alter the result.
- rst asserted during EMIT of an L=10 request -> next cycle all outputs 0, state IDLE. A fresh L=3 "abc" request then yields 61 00 62 00 63 00 80, byte56=0x30.
